muxn_scan: RTL
==============

# muxn_scan

Parametrised, registered N-channel, W-bit multiplexer with a manual-select mode and an automatic scan mode. It generalises the 3:1 single-bit lab multiplexers. Channel count and data width are parameters, the output is registered, and an internal dwell counter can step through the channels round-robin. It is intended as the data-path selector in lab top levels where an input bank is displayed or sampled one channel at a time.

## Interface
- N, default 3: number of input channels; legal range N ≥ 2.
- W, default 1: data width per channel, W ≥ 1.
- DWELL, default 4: cycles spent on each channel in scan mode; DWELL ≥ 1.
- SW (localparam) = $clog2(N): select/channel index width.
- clk, input, 1: sole clock; all state updates on the rising edge.
- rst_n, input, 1: reset, synchronous, active-low.
- x, input, N*W: packed channel data; channel k occupies x[k*W +: W].
- sel, input, SW: channel request in manual mode.
- mode, input, 1: 0 = manual, 1 = scan.
- hold, input, 1: freezes channel index and dwell counter.
- f, output, W: registered selected data.
- ch, output, SW: current channel index; it is coherent with f.
- step, output, 1: one-cycle pulse when ch changed on the last edge.
- sel_err, output, 1: registered flag that sel ≥ N was presented in manual mode.

## Operation
- Internal state: ch register (SW bits), dwell counter cnt (width $clog2(DWELL)+1), f, step, sel_err.
- Reset (rst_n=0 at an edge): ch=0, cnt=0, f=0, step=0, sel_err=0. Reset mid-scan aborts the scan and restarts at channel 0.
- Next-channel ch_nx, with priority top-down:
  - If hold=1, ch_nx = ch.
  - If mode=0 and sel < N, ch_nx = sel.
  - If mode=0 and sel ≥ N, ch_nx = ch; the request is ignored.
  - If mode=1 and cnt == DWELL-1, ch_nx = (ch == N-1) ? 0 : ch+1.
  - If mode=1 otherwise, ch_nx = ch.
- Dwell counter:
  - hold=1: cnt holds.
  - mode=0: cnt is cleared to 0.
  - mode=1: cnt increments, and wraps to 0 after DWELL-1.
  - DWELL=1: ch advances every cycle.
- Mode change manual→scan: scan starts from the current ch with cnt=0, so the first advance comes DWELL cycles later.
- Mode change scan→manual: sel takes effect on the same edge.
- Each edge (not in reset): ch ← ch_nx; f ← x[ch_nx*W +: W]; step ← (ch_nx ≠ ch).
- While hold=1, f keeps sampling x on the frozen channel; data is not frozen.
- sel_err ← (mode=0 && hold=0 && sel ≥ N); it is re-evaluated every cycle and is not sticky.
- When N is a power of two, sel ≥ N cannot occur and sel_err stays 0.

## Timing
- Latency is 1 cycle. After edge t, f equals the slice of channel ch (new value) of x as sampled at edge t.
- Manual select: sel applied before edge t gives ch=sel and f=x[sel] after edge t.
- Scan period: each channel is held for exactly DWELL cycles. A full rotation takes N*DWELL cycles. The ch=N-1→0 wrap costs no extra cycle.
- step is high for exactly the one cycle after any edge where ch changed. It is 0 when the manual sel equals the current ch.
- hold and mode are sampled at the same edge as everything else; there are no combinational paths from inputs to outputs.

## Test plan
Parameters for all scenarios: N=3, W=4, DWELL=2.
- Reset: drive rst_n=0 for 2 cycles with x=0xCBA -> f=0, ch=0, step=0, sel_err=0. Release in manual mode with sel=0 -> f=0xA.
- Manual select: x=0xCBA; set sel=2, then sel=1, then sel=1 on successive edges -> f = 0xC, 0xB, 0xB; step = 1, 1, 0.
- Illegal select: in manual mode on ch=1, present sel=3 -> ch stays 1, f=0xB, sel_err=1 for that cycle. With sel=0 next -> ch=0, sel_err=0.
- Scan: set mode=1 from ch=0 with x=0xCBA; run 8 cycles -> ch sequence 0,0,1,1,2,2,0,0; f follows A,A,B,B,C,C,A,A; step pulses on each change, including the 2→0 wrap.
- Hold: in scan at ch=1 with cnt=1, hold for 3 cycles while x[1] changes 0xB→0x5 -> ch stays 1, f updates to 0x5, no step. On release, ch becomes 2 after one edge.
- Reset mid-scan: assert rst_n=0 for one edge at ch=2 -> ch=0, f=0, cnt=0. Scan resumes with 2 cycles on channel 0.

Source files
------------

// File: rtl/muxn_scan.sv
// Registered N-channel, W-bit selector with manual select and round-robin scan.
// ch and f are updated on the same edge from the same next-channel value.
module muxn_scan #(
    parameter int N     = 3,
    parameter int W     = 1,
    parameter int DWELL = 4,
    localparam int SW   = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N*W-1:0]  x,
    input  logic [SW-1:0]   sel,
    input  logic            mode,
    input  logic            hold,
    output logic [W-1:0]    f,
    output logic [SW-1:0]   ch,
    output logic            step,
    output logic            sel_err
);

    localparam int CW = $clog2(DWELL) + 1;

    localparam logic [SW:0]   N_EXT      = (SW + 1)'(N);
    localparam logic [SW-1:0] CH_LAST    = SW'(N - 1);
    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);

    logic [SW-1:0] ch_q, ch_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  f_q, f_d;
    logic          step_q, step_d;
    logic          sel_err_q, sel_err_d;

    logic          sel_ok;
    logic          dwell_done;

    // Zero-extend sel so the compare also works when N is a power of two.
    assign sel_ok     = ({1'b0, sel} < N_EXT);
    assign dwell_done = (cnt_q == DWELL_LAST);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        ch_d = ch_q;
        if (hold) begin
            ch_d = ch_q;
        end else if (!mode) begin
            if (sel_ok) begin
                ch_d = sel;
            end
        end else if (dwell_done) begin
            ch_d = (ch_q == CH_LAST) ? '0 : ch_q + 1'b1;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (hold) begin
            cnt_d = cnt_q;
        end else if (!mode) begin
            cnt_d = '0;
        end else if (dwell_done) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Data follows the next channel so f and ch stay coherent after each edge.
    always_comb begin
        f_d = '0;
        for (int k = 0; k < N; k++) begin
            if (ch_d == SW'(k)) begin
                f_d = x[k*W +: W];
            end
        end
    end

    assign step_d    = (ch_d != ch_q);
    assign sel_err_d = !mode && !hold && !sel_ok;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!rst_n) begin
            ch_q      <= '0;
            cnt_q     <= '0;
            f_q       <= '0;
            step_q    <= 1'b0;
            sel_err_q <= 1'b0;
        end else begin
            ch_q      <= ch_d;
            cnt_q     <= cnt_d;
            f_q       <= f_d;
            step_q    <= step_d;
            sel_err_q <= sel_err_d;
        end
    end

    assign f       = f_q;
    assign ch      = ch_q;
    assign step    = step_q;
    assign sel_err = sel_err_q;

endmodule
